// File: rtl/booth_r4_mul_seq_if.sv
// Launch/result bundle for booth_r4_mul_seq: operands and mode in, product and status out.
interface booth_r4_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
    logic               rdy;
    logic               busy;

    modport master (
        output start, signed_mode, a, b,
        input  p, rdy, busy
    );

    modport slave (
        input  start, signed_mode, a, b,
        output p, rdy, busy
    );
endinterface

// File: rtl/booth_r4_mul_seq.sv
// Sequential radix-4 Booth multiplier: one recoded digit per cycle, signed or
// unsigned operands, fixed latency of WIDTH/2+1 iterations per launch.
module booth_r4_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    booth_r4_mul_seq_if.slave bus
);
    localparam int N     = WIDTH / 2 + 1;
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;   // multiplicand, already shifted left by 2i
    logic [WIDTH+2:0]   mplr_q, mplr_d;     // extended multiplier with implicit 0 below LSB
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [ACC_W-1:0]   addend;
    logic               a_sx, b_sx;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        p_d     = p_q;
        addend  = '0;
        a_sx    = bus.signed_mode & bus.a[WIDTH-1];
        b_sx    = bus.signed_mode & bus.b[WIDTH-1];

        // Booth digit from the low triplet: {b[2i+1], b[2i], b[2i-1]}
        case (mplr_q[2:0])
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = mcand_q << 1;
            3'b100:         addend = -(mcand_q << 1);
            3'b101, 3'b110: addend = -mcand_q;
            default:        addend = '0;
        endcase

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcand_d = {{(ACC_W - WIDTH){a_sx}}, bus.a};
                    mplr_d  = {{2{b_sx}}, bus.b, 1'b0};
                end
            end
            RUN: begin
                acc_d   = acc_q + addend;
                mcand_d = mcand_q << 2;
                mplr_d  = mplr_q >> 2;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    p_d     = acc_d[2*WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.rdy  = (state_q == DONE);
    assign bus.p    = p_q;
endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// Randomised and directed bench for booth_r4_mul_seq at WIDTH = 4, 8 and 16,
// checked against a plain-arithmetic product model.
module tb_booth_r4_mul_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    booth_r4_mul_seq_if #(.WIDTH(4))  if4 ();
    booth_r4_mul_seq_if #(.WIDTH(8))  if8 ();
    booth_r4_mul_seq_if #(.WIDTH(16)) if16 ();

    booth_r4_mul_seq #(.WIDTH(4))  u_dut4  (.clk(clk), .reset(reset), .bus(if4));
    booth_r4_mul_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(if8));
    booth_r4_mul_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic sm,
                         input logic [15:0] av, input logic [15:0] bv);
        case (w)
            4: begin if4.start = st; if4.signed_mode = sm; if4.a = av[3:0]; if4.b = bv[3:0]; end
            8: begin if8.start = st; if8.signed_mode = sm; if8.a = av[7:0]; if8.b = bv[7:0]; end
            default: begin if16.start = st; if16.signed_mode = sm; if16.a = av; if16.b = bv; end
        endcase
    endtask

    task automatic set_start(input int w, input logic st);
        case (w)
            4:       if4.start = st;
            8:       if8.start = st;
            default: if16.start = st;
        endcase
    endtask

    function automatic logic [31:0] get_p(input int w);
        case (w)
            4:       return {28'b0, if4.p};
            8:       return {16'b0, if8.p};
            default: return if16.p;
        endcase
    endfunction

    function automatic logic get_rdy(input int w);
        case (w)
            4:       return if4.rdy;
            8:       return if8.rdy;
            default: return if16.rdy;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            4:       return if4.busy;
            8:       return if8.busy;
            default: return if16.busy;
        endcase
    endfunction

    // Reference: interpret operands as signed or unsigned integers, multiply, keep 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic sm,
                                            input logic [15:0] av, input logic [15:0] bv);
        longint span, x, y, prod;
        span = longint'(1) << w;
        x = longint'(av) & (span - 1);
        y = longint'(bv) & (span - 1);
        if (sm && x >= span / 2) x = x - span;
        if (sm && y >= span / 2) y = y - span;
        prod = (x * y) & ((longint'(1) << (2 * w)) - 1);
        return prod[31:0];
    endfunction

    // Launch at a falling edge, release start after E0, wait (bounded) for rdy.
    // lat counts rising edges from E0 up to and including the completion edge.
    task automatic run_one(input int w, input logic sm, input logic [15:0] av,
                           input logic [15:0] bv, output logic [31:0] pr, output int lat);
        logic [31:0] prev;
        logic        bad;
        prev = get_p(w);
        bad  = 1'b0;
        lat  = 0;
        drive(w, 1'b1, sm, av, bv);
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) set_start(w, 1'b0);
            if (get_busy(w) && get_rdy(w)) bad = 1'b1;
            if (!get_rdy(w) && (!get_busy(w) || get_p(w) !== prev)) bad = 1'b1;
        end while (!get_rdy(w) && lat < 64);
        pr = get_p(w);
        check($sformatf("w%0d_proto", w), 64'(bad), 64'(0));
    endtask

    task automatic mul_check(input string tag, input int w, input logic sm,
                             input logic [15:0] av, input logic [15:0] bv,
                             input logic [31:0] exp);
        logic [31:0] pr;
        int          lat;
        run_one(w, sm, av, bv, pr, lat);
        check({tag, "_p"}, 64'(pr), 64'(exp));
        check({tag, "_lat"}, 64'(lat), 64'(w / 2 + 2));
    endtask

    initial begin
        logic [31:0] pr;
        int          lat;
        int          low;
        logic [15:0] ra, rb;
        logic        rsm;
        int          widths [3] = '{4, 8, 16};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(widths[i], 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w%0d_rst_p", widths[i]), 64'(get_p(widths[i])), 64'(0));
            check($sformatf("w%0d_rst_rdy", widths[i]), 64'(get_rdy(widths[i])), 64'(0));
            check($sformatf("w%0d_rst_busy", widths[i]), 64'(get_busy(widths[i])), 64'(0));
        end

        // Signed and unsigned corners at WIDTH=8
        mul_check("s_80x80", 8, 1'b1, 16'h80, 16'h80, 32'h4000);
        mul_check("s_FFx7F", 8, 1'b1, 16'hFF, 16'h7F, 32'hFF81);
        mul_check("u_FFxFF", 8, 1'b0, 16'hFF, 16'hFF, 32'hFE01);
        mul_check("s_FFxFF", 8, 1'b1, 16'hFF, 16'hFF, 32'h0001);

        // start pulsed during RUN is ignored
        drive(8, 1'b1, 1'b0, 16'h03, 16'h05);
        @(posedge clk);
        @(negedge clk); set_start(8, 1'b0);
        @(posedge clk);
        @(negedge clk); drive(8, 1'b1, 1'b0, 16'h10, 16'h10);
        @(posedge clk);
        @(negedge clk); set_start(8, 1'b0);
        lat = 3;
        while (!get_rdy(8) && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("ign_p", 64'(get_p(8)), 64'h000F);
        check("ign_lat", 64'(lat), 64'(6));

        // Relaunch from DONE with start held high
        drive(8, 1'b1, 1'b1, 16'h07, 16'hFE);
        low = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            if (!get_rdy(8)) low++;
        end while (!get_rdy(8) && low < 64);
        check("b2b_low", 64'(low), 64'(5));
        check("b2b_p", 64'(get_p(8)), 64'hFFF2);
        @(posedge clk);
        @(negedge clk);
        check("b2b_rdy_pulse", 64'(get_rdy(8)), 64'(0));
        check("b2b_busy", 64'(get_busy(8)), 64'(1));
        set_start(8, 1'b0);
        low = 0;
        while (!get_rdy(8) && low < 64) begin
            @(posedge clk);
            low++;
            @(negedge clk);
        end
        check("b2b_p2", 64'(get_p(8)), 64'hFFF2);

        // Reset asserted at E3 aborts the run
        drive(8, 1'b1, 1'b0, 16'h55, 16'h33);
        @(posedge clk);
        @(negedge clk); set_start(8, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        check("abort_busy", 64'(get_busy(8)), 64'(0));
        check("abort_rdy", 64'(get_rdy(8)), 64'(0));
        check("abort_p", 64'(get_p(8)), 64'(0));
        mul_check("after_abort", 8, 1'b0, 16'h55, 16'h33, 32'h10EF);

        // WIDTH=16 corners
        mul_check("w16_s", 16, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
        mul_check("w16_u", 16, 1'b0, 16'h8000, 16'h7FFF, 32'h3FFF8000);

        // Randomised sweep, launches back-to-back from DONE
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 2000; k++) begin
                ra  = 16'($urandom);
                rb  = 16'($urandom);
                rsm = 1'($urandom_range(0, 1));
                run_one(widths[i], rsm, ra, rb, pr, lat);
                check($sformatf("w%0d_rnd_p", widths[i]), 64'(pr),
                      64'(ref_mul(widths[i], rsm, ra, rb)));
                check($sformatf("w%0d_rnd_lat", widths[i]), 64'(lat), 64'(widths[i] / 2 + 2));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
